md5_cmd_sequencer: RTL and testbench

//  Command-initiator side of the 32-bit strobe/word command protocol served by the MD5 brute-force core.

---
 rtl/md5_cmd_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_md5_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_cmd_sequencer.sv
// Command initiator for the MD5 brute-force core: programs one crack job over the
// strobe/word link, polls the attempt counter and reports match, exhaustion or a bad acknowledge.
module md5_cmd_sequencer #(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned MAX_POLLS     = 65535
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_job_valid,
  output logic         o_job_ready,
  input  logic [127:0] i_job_hash,
  input  logic [7:0]   i_job_min,
  input  logic [7:0]   i_job_max,
  input  logic         i_abort,
  output logic [31:0]  o_cmd_data,
  output logic         o_cmd_strobe,
  input  logic [31:0]  i_rsp_data,
  input  logic         i_has_matched,
  input  logic [127:0] i_match_text,
  output logic         o_done,
  output logic         o_matched,
  output logic         o_error,
  output logic [127:0] o_result_text,
  output logic [63:0]  o_attempts
);

  localparam logic [31:0] C_RESET     = 32'h5230_0000;
  localparam logic [31:0] C_POLL_LO   = 32'h5230_3000;
  localparam logic [31:0] C_POLL_HI   = 32'h5230_3001;
  localparam logic [31:0] L_STROBE_LAST = 32'(STROBE_CYCLES - 1);
  localparam logic [31:0] L_GAP_LAST    = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] L_POLL_LAST   = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] L_MAX_POLLS   = 32'(MAX_POLLS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_CHECK, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {P_PROG, P_POLL_LO, P_POLL_HI, P_FINAL} phase_t;

  state_t        r_state, w_stateNext;
  phase_t        r_phase, w_phaseNext;
  logic [3:0]    r_step, w_stepNext;
  logic [31:0]   r_cnt, w_cntNext;
  logic [31:0]   r_polls, w_pollsNext;
  logic [31:0]   r_cmdData, w_cmdDataNext;
  logic          r_errFlag, w_errNext;
  logic          r_matchFlag, w_matchNext;
  logic [127:0]  r_textCap, w_textNext;
  logic [63:0]   r_attempts, w_attemptsNext;
  logic [31:0]   r_lowWord, w_lowNext;
  logic [127:0]  r_hash;
  logic [7:0]    r_min, r_max;
  logic          r_cmdStrobe, r_jobReady, r_done, r_matched, r_error;
  logic [127:0]  r_resultText;
  logic          w_accept, w_lastPoll, w_abortNow;

  function automatic logic [31:0] f_progWord(input logic [3:0] step, input logic [127:0] hash,
                                             input logic [7:0] lo, input logic [7:0] hi);
    case (step)
      4'd0:    f_progWord = C_RESET;
      4'd1:    f_progWord = 32'h5230_1000;
      4'd2:    f_progWord = hash[127:96];
      4'd3:    f_progWord = 32'h5230_1001;
      4'd4:    f_progWord = hash[95:64];
      4'd5:    f_progWord = 32'h5230_1002;
      4'd6:    f_progWord = hash[63:32];
      4'd7:    f_progWord = 32'h5230_1003;
      4'd8:    f_progWord = hash[31:0];
      4'd9:    f_progWord = 32'h5230_2000;
      4'd10:   f_progWord = {16'h0000, hi, lo};
      default: f_progWord = 32'h5230_0001;
    endcase
  endfunction

  function automatic logic [31:0] f_progAck(input logic [3:0] step);
    case (step)
      4'd0:    f_progAck = 32'hFFFF_FFFF;
      4'd2:    f_progAck = 32'h00FF_00FF;
      4'd4:    f_progAck = 32'hFF00_FF00;
      4'd6:    f_progAck = 32'hFFFF_0000;
      4'd8:    f_progAck = 32'h0000_FFFF;
      4'd10:   f_progAck = 32'hAAAA_AAAA;
      4'd11:   f_progAck = 32'h5555_5555;
      default: f_progAck = 32'h0000_0000;
    endcase
  endfunction

  assign w_lastPoll = (L_MAX_POLLS != 32'd0) && ((r_polls + 32'd1) >= L_MAX_POLLS);
  assign w_abortNow = i_abort && (r_state != S_IDLE) && (r_state != S_DONE) && (r_phase != P_FINAL);

  // Every path out of a job funnels through one final reset word (phase P_FINAL) before DONE.
  always_comb begin
    w_stateNext    = r_state;
    w_phaseNext    = r_phase;
    w_stepNext     = r_step;
    w_cntNext      = r_cnt;
    w_pollsNext    = r_polls;
    w_cmdDataNext  = r_cmdData;
    w_errNext      = r_errFlag;
    w_matchNext    = r_matchFlag;
    w_textNext     = r_textCap;
    w_attemptsNext = r_attempts;
    w_lowNext      = r_lowWord;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_job_valid) begin
          w_accept      = 1'b1;
          w_phaseNext   = P_PROG;
          w_stepNext    = 4'd0;
          w_cmdDataNext = C_RESET;
          w_errNext     = 1'b0;
          w_matchNext   = 1'b0;
          w_stateNext   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cntNext   = 32'd0;
        w_stateNext = S_SEND;
      end
      S_SEND: begin
        if (r_cnt == L_STROBE_LAST) begin
          w_cntNext   = 32'd0;
          w_stateNext = S_GAP;
        end else begin
          w_cntNext = r_cnt + 32'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == L_GAP_LAST) w_stateNext = S_CHECK;
        else w_cntNext = r_cnt + 32'd1;
      end
      S_CHECK: begin
        case (r_phase)
          P_PROG: begin
            if (i_rsp_data != f_progAck(r_step)) begin
              w_errNext = 1'b1;
              w_phaseNext = P_FINAL; w_cmdDataNext = C_RESET; w_stateNext = S_LOAD;
            end else if (i_has_matched) begin
              w_matchNext = 1'b1;
              w_textNext  = i_match_text;
              w_phaseNext = P_FINAL; w_cmdDataNext = C_RESET; w_stateNext = S_LOAD;
            end else if (r_step == 4'd11) begin
              w_cntNext   = 32'd0;
              w_pollsNext = 32'd0;
              w_stateNext = S_RUN;
            end else begin
              w_stepNext    = r_step + 4'd1;
              w_cmdDataNext = f_progWord(r_step + 4'd1, r_hash, r_min, r_max);
              w_stateNext   = S_LOAD;
            end
          end
          P_POLL_LO: begin
            w_lowNext = i_rsp_data;
            if (i_has_matched) begin
              w_matchNext = 1'b1;
              w_textNext  = i_match_text;
              w_phaseNext = P_FINAL; w_cmdDataNext = C_RESET; w_stateNext = S_LOAD;
            end else begin
              w_phaseNext = P_POLL_HI; w_cmdDataNext = C_POLL_HI; w_stateNext = S_LOAD;
            end
          end
          P_POLL_HI: begin
            w_attemptsNext = {i_rsp_data, r_lowWord};
            w_pollsNext    = r_polls + 32'd1;
            if (i_has_matched) begin
              w_matchNext = 1'b1;
              w_textNext  = i_match_text;
              w_phaseNext = P_FINAL; w_cmdDataNext = C_RESET; w_stateNext = S_LOAD;
            end else if (w_lastPoll) begin
              w_phaseNext = P_FINAL; w_cmdDataNext = C_RESET; w_stateNext = S_LOAD;
            end else begin
              w_cntNext   = 32'd0;
              w_stateNext = S_RUN;
            end
          end
          default: w_stateNext = S_DONE;
        endcase
      end
      S_RUN: begin
        if (i_has_matched) begin
          w_matchNext = 1'b1;
          w_textNext  = i_match_text;
          w_phaseNext = P_FINAL; w_cmdDataNext = C_RESET; w_stateNext = S_LOAD;
        end else if (r_cnt == L_POLL_LAST) begin
          w_phaseNext = P_POLL_LO; w_cmdDataNext = C_POLL_LO; w_stateNext = S_LOAD;
        end else begin
          w_cntNext = r_cnt + 32'd1;
        end
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
    if (w_abortNow) begin
      w_errNext     = 1'b0;
      w_matchNext   = 1'b0;
      w_phaseNext   = P_FINAL;
      w_cmdDataNext = C_RESET;
      w_stateNext   = S_LOAD;
    end
  end

  // Strobe, ready and done are registered decodes of the next state so they never glitch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_phase      <= P_PROG;
      r_step       <= 4'd0;
      r_cnt        <= 32'd0;
      r_polls      <= 32'd0;
      r_cmdData    <= 32'd0;
      r_errFlag    <= 1'b0;
      r_matchFlag  <= 1'b0;
      r_textCap    <= 128'd0;
      r_attempts   <= 64'd0;
      r_lowWord    <= 32'd0;
      r_hash       <= 128'd0;
      r_min        <= 8'd0;
      r_max        <= 8'd0;
      r_cmdStrobe  <= 1'b0;
      r_jobReady   <= 1'b1;
      r_done       <= 1'b0;
      r_matched    <= 1'b0;
      r_error      <= 1'b0;
      r_resultText <= 128'd0;
    end else begin
      r_state     <= w_stateNext;
      r_phase     <= w_phaseNext;
      r_step      <= w_stepNext;
      r_cnt       <= w_cntNext;
      r_polls     <= w_pollsNext;
      r_cmdData   <= w_cmdDataNext;
      r_errFlag   <= w_errNext;
      r_matchFlag <= w_matchNext;
      r_textCap   <= w_textNext;
      r_attempts  <= w_attemptsNext;
      r_lowWord   <= w_lowNext;
      r_cmdStrobe <= (w_stateNext == S_SEND);
      r_jobReady  <= (w_stateNext == S_IDLE);
      r_done      <= (w_stateNext == S_DONE);
      if (w_accept) begin
        r_hash       <= i_job_hash;
        r_min        <= i_job_min;
        r_max        <= i_job_max;
        r_matched    <= 1'b0;
        r_error      <= 1'b0;
        r_resultText <= 128'd0;
      end
      if (w_stateNext == S_DONE) begin
        r_matched    <= r_matchFlag;
        r_error      <= r_errFlag;
        r_resultText <= r_matchFlag ? r_textCap : 128'd0;
      end
    end
  end

  assign o_job_ready   = r_jobReady;
  assign o_cmd_data    = r_cmdData;
  assign o_cmd_strobe  = r_cmdStrobe;
  assign o_done        = r_done;
  assign o_matched     = r_matched;
  assign o_error       = r_error;
  assign o_result_text = r_resultText;
  assign o_attempts    = r_attempts;

endmodule

// File: tb/tb_md5_cmd_sequencer.sv
// Self-checking bench for md5_cmd_sequencer: a responder model answers the command link
// while a scoreboard queue holds the word order each job must produce.
module tb_md5_cmd_sequencer;

  localparam int STROBE = 4;
  localparam int GAP    = 4;
  localparam int POLLIV = 16;
  localparam int MAXP   = 3;
  localparam logic [31:0] RESET_WORD = 32'h5230_0000;
  localparam logic [31:0] POLL_LO    = 32'h5230_3000;
  localparam logic [31:0] POLL_HI    = 32'h5230_3001;
  localparam logic [127:0] HASH_A    = 128'h2971bc83_9b41f6a4_955620c0_9067fbfd;
  localparam logic [127:0] ABC_TEXT  = 128'h616263;

  logic         clock = 1'b0;
  logic         reset;
  logic         jobValid;
  logic         jobReady;
  logic [127:0] jobHash;
  logic [7:0]   jobMin, jobMax;
  logic         abort;
  logic [31:0]  cmdData;
  logic         cmdStrobe;
  logic [31:0]  rspData;
  logic         hasMatched;
  logic [127:0] matchText;
  logic         done, matched, error;
  logic [127:0] resultText;
  logic [63:0]  attempts;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] expQ[$];
  bit          prevStrobe, expectData, running, badC, widthExempt;
  int          dataSel, respPolls, matchAfter, strobeWidth, wordCount, accepts;
  logic [63:0] count, respAttempts;
  logic [31:0] lastLo;

  md5_cmd_sequencer #(
    .STROBE_CYCLES(STROBE), .GAP_CYCLES(GAP), .POLL_INTERVAL(POLLIV), .MAX_POLLS(MAXP)
  ) dut (
    .i_clk(clock), .i_reset(reset), .i_job_valid(jobValid), .o_job_ready(jobReady),
    .i_job_hash(jobHash), .i_job_min(jobMin), .i_job_max(jobMax), .i_abort(abort),
    .o_cmd_data(cmdData), .o_cmd_strobe(cmdStrobe), .i_rsp_data(rspData),
    .i_has_matched(hasMatched), .i_match_text(matchText), .o_done(done),
    .o_matched(matched), .o_error(error), .o_result_text(resultText), .o_attempts(attempts)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] progWord(input int step, input logic [127:0] h,
                                           input logic [7:0] mn, input logic [7:0] mx);
    case (step)
      0:  return RESET_WORD;
      1:  return 32'h5230_1000;
      2:  return h[127:96];
      3:  return 32'h5230_1001;
      4:  return h[95:64];
      5:  return 32'h5230_1002;
      6:  return h[63:32];
      7:  return 32'h5230_1003;
      8:  return h[31:0];
      9:  return 32'h5230_2000;
      10: return {16'h0000, mx, mn};
      default: return 32'h5230_0001;
    endcase
  endfunction

  task automatic pushJob(input logic [127:0] h, input logic [7:0] mn, input logic [7:0] mx,
                         input int lastStep, input int polls);
    for (int s = 0; s <= lastStep; s++) expQ.push_back(progWord(s, h, mn, mx));
    for (int p = 0; p < polls; p++) begin
      expQ.push_back(POLL_LO);
      expQ.push_back(POLL_HI);
    end
    expQ.push_back(RESET_WORD);
  endtask

  // Offer one job for a single cycle, then scramble the job inputs to show they are not re-read.
  task automatic applyStimulus(input logic [127:0] h, input logic [7:0] mn, input logic [7:0] mx,
                               input int lastStep, input int polls);
    pushJob(h, mn, mx, lastStep, polls);
    @(negedge clock);
    jobHash  = h;
    jobMin   = mn;
    jobMax   = mx;
    jobValid = 1'b1;
    @(negedge clock);
    checkOutput("readyAfterAccept", 128'(jobReady), 128'(0));
    jobValid = 1'b0;
    jobHash  = ~h;
    jobMin   = ~mn;
    jobMax   = ~mx;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done) break;
    end
    checkOutput("doneSeen", 128'(done), 128'(1));
    checkOutput("noReadyWithDone", 128'(jobReady), 128'(0));
    checkOutput("queueDrained", 128'(expQ.size()), 128'(0));
  endtask

  always @(posedge clock) if (!reset && jobValid && jobReady) accepts++;

  // Ideal responder: acts on each strobe rising edge, checked against the scoreboard queue.
  always @(negedge clock) begin
    if (reset) begin
      prevStrobe = 1'b0; expectData = 1'b0; running = 1'b0; hasMatched = 1'b0;
      rspData = 32'd0; respPolls = 0; count = 64'd0; strobeWidth = 0;
    end else begin
      if (running) count++;
      if (cmdStrobe) strobeWidth++;
      if (cmdStrobe && !prevStrobe) begin
        wordCount++;
        widthExempt = 1'b0;
        if (expQ.size() == 0) checkOutput("extraWord", 128'(expQ.size()), 128'(1));
        else checkOutput("wordOrder", 128'(cmdData), 128'(expQ.pop_front()));
        if (expectData) begin
          expectData = 1'b0;
          case (dataSel)
            0: rspData = 32'h00FF_00FF;
            1: rspData = 32'hFF00_FF00;
            2: rspData = badC ? 32'h0 : 32'hFFFF_0000;
            3: rspData = 32'h0000_FFFF;
            default: rspData = 32'hAAAA_AAAA;
          endcase
        end else begin
          case (cmdData)
            32'h5230_0000: begin
              rspData = 32'hFFFF_FFFF; running = 1'b0; hasMatched = 1'b0; respPolls = 0;
            end
            32'h5230_1000, 32'h5230_1001, 32'h5230_1002, 32'h5230_1003: begin
              rspData = 32'h0; expectData = 1'b1; dataSel = int'(cmdData[1:0]);
            end
            32'h5230_2000: begin
              rspData = 32'h0; expectData = 1'b1; dataSel = 4;
            end
            32'h5230_0001: begin
              rspData = 32'h5555_5555; running = 1'b1; count = 64'h0000_0001_FFFF_FFE0;
            end
            32'h5230_3000: begin
              rspData = count[31:0]; lastLo = count[31:0];
            end
            32'h5230_3001: begin
              rspData = count[63:32];
              respAttempts = {count[63:32], lastLo};
              respPolls++;
              if (matchAfter != 0 && respPolls == matchAfter) hasMatched = 1'b1;
            end
            default: rspData = 32'hDEAD_BEEF;
          endcase
        end
      end
      if (!cmdStrobe && prevStrobe) begin
        if (!widthExempt) checkOutput("strobeWidth", 128'(strobeWidth), 128'(STROBE));
        strobeWidth = 0;
      end
      prevStrobe = cmdStrobe;
    end
  end

  initial begin
    int base;
    reset = 1'b1; jobValid = 1'b0; abort = 1'b0; jobHash = '0; jobMin = '0; jobMax = '0;
    matchAfter = 0; badC = 1'b0; widthExempt = 1'b0; wordCount = 0; accepts = 0;
    matchText = ABC_TEXT; respAttempts = '0; lastLo = '0; dataSel = 0;
    repeat (3) @(negedge clock);
    checkOutput("rstReady", 128'(jobReady), 128'(1));
    checkOutput("rstStrobe", 128'(cmdStrobe), 128'(0));
    checkOutput("rstData", 128'(cmdData), 128'(0));
    checkOutput("rstDone", 128'(done), 128'(0));
    checkOutput("rstAttempts", 128'(attempts), 128'(0));
    reset = 1'b0;

    // Unmatched job running to poll exhaustion.
    applyStimulus(HASH_A, 8'h61, 8'h7a, 11, MAXP);
    waitDone();
    checkOutput("exhaustMatched", 128'(matched), 128'(0));
    checkOutput("exhaustError", 128'(error), 128'(0));
    checkOutput("exhaustText", resultText, 128'(0));
    checkOutput("exhaustAttempts", 128'(attempts), 128'(respAttempts));
    @(negedge clock);
    checkOutput("readyAfterDone", 128'(jobReady), 128'(1));
    checkOutput("donePulse", 128'(done), 128'(0));

    // Match raised on the last allowed poll: match must win over expiry.
    matchAfter = 3;
    applyStimulus(HASH_A, 8'h61, 8'h7a, 11, 3);
    waitDone();
    checkOutput("matchMatched", 128'(matched), 128'(1));
    checkOutput("matchText", resultText, ABC_TEXT);
    checkOutput("matchAttempts", 128'(attempts), 128'(respAttempts));
    checkOutput("matchAttemptsNonzero", 128'(attempts != 64'd0), 128'(1));
    repeat (3) @(negedge clock);
    checkOutput("matchHeld", 128'(matched), 128'(1));
    matchAfter = 0;

    // Bad acknowledge on data word C.
    badC = 1'b1;
    applyStimulus(128'h01234567_89abcdef_fedcba98_76543210, 8'h30, 8'h39, 6, 0);
    waitDone();
    checkOutput("errError", 128'(error), 128'(1));
    checkOutput("errMatched", 128'(matched), 128'(0));
    checkOutput("errLastWord", 128'(cmdData), 128'(RESET_WORD));
    badC = 1'b0;

    // Abort during the strobe of step 5.
    base = wordCount;
    applyStimulus(HASH_A, 8'h41, 8'h5a, 5, 0);
    for (int i = 0; i < 500; i++) begin
      if (wordCount >= base + 6 && cmdStrobe) break;
      @(negedge clock);
    end
    checkOutput("abortReachedStep5", 128'(cmdStrobe), 128'(1));
    abort = 1'b1;
    widthExempt = 1'b1;
    @(negedge clock);
    checkOutput("abortStrobeDrop", 128'(cmdStrobe), 128'(0));
    abort = 1'b0;
    waitDone();
    checkOutput("abortMatched", 128'(matched), 128'(0));
    checkOutput("abortError", 128'(error), 128'(0));
    @(negedge clock);
    checkOutput("abortReady", 128'(jobReady), 128'(1));

    // job_valid held high: one accept per job, second job taken right after the first ends.
    accepts = 0;
    pushJob(HASH_A, 8'h61, 8'h7a, 11, MAXP);
    pushJob(HASH_A, 8'h61, 8'h7a, 11, MAXP);
    jobHash = HASH_A; jobMin = 8'h61; jobMax = 8'h7a; jobValid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done) break;
    end
    checkOutput("b2bFirstDone", 128'(done), 128'(1));
    checkOutput("b2bOneAccept", 128'(accepts), 128'(1));
    @(negedge clock);
    checkOutput("b2bReadyAgain", 128'(jobReady), 128'(1));
    @(negedge clock);
    jobValid = 1'b0;
    checkOutput("b2bSecondAccept", 128'(accepts), 128'(2));
    waitDone();
    checkOutput("b2bAcceptTotal", 128'(accepts), 128'(2));

    // Reset while polling.
    applyStimulus(HASH_A, 8'h61, 8'h7a, 11, MAXP);
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (running) break;
    end
    checkOutput("runReached", 128'(running), 128'(1));
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midRstReady", 128'(jobReady), 128'(1));
    checkOutput("midRstStrobe", 128'(cmdStrobe), 128'(0));
    checkOutput("midRstData", 128'(cmdData), 128'(0));
    checkOutput("midRstDone", 128'(done), 128'(0));
    checkOutput("midRstMatched", 128'(matched), 128'(0));
    checkOutput("midRstError", 128'(error), 128'(0));
    checkOutput("midRstText", resultText, 128'(0));
    checkOutput("midRstAttempts", 128'(attempts), 128'(0));
    expQ.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
